// File: rtl/cdf_lut_builder.sv
// ============================================================================
//  Module      : cdf_lut_builder
//  Description : Histogram-equalisation LUT builder. Walks the histogram,
//                accumulates the CDF, scales it through an external divider
//                and writes the saturated 8-bit level into the LUT BRAM.
//                Optional macro CDF_MIN_EN selects standard (cdf_min based)
//                equalisation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cdf_lut_builder #(
    parameter int W               = 64,
    parameter int H               = 64,
    parameter int LEVELS          = 256,
    parameter int TOTAL_PIXEL     = W * H,
    parameter int TOTAL_PIXEL_BIT = $clog2(W * H),
    parameter int BIN_BIT         = $clog2(LEVELS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       hist_rd_en,
    output logic [BIN_BIT-1:0]         hist_addr,
    input  logic [TOTAL_PIXEL_BIT:0]   hist_data,
    output logic                       div_start,
    output logic [31:0]                div_dividend,
    output logic [TOTAL_PIXEL_BIT:0]   div_divisor,
    input  logic                       div_done,
    input  logic [31:0]                div_quotient,
    output logic                       lut_we,
    output logic [BIN_BIT-1:0]         lut_addr,
    output logic [7:0]                 lut_data
);

    localparam int CW = TOTAL_PIXEL_BIT + 1;

    if (CW + BIN_BIT > 32) begin : g_width_check
        $error("cdf_lut_builder: CDF*(LEVELS-1) does not fit in 32 bits");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_ACC  = 3'd3,
        S_LOAD = 3'd4,
        S_DIVW = 3'd5,
        S_WR   = 3'd6,
        S_FIN  = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [BIN_BIT-1:0]  r_bin;
    logic [CW-1:0]       r_cdf;
    logic [31:0]         r_q;
    logic                w_bypass;
    logic [31:0]         w_dividend;
    logic [CW-1:0]       w_divisor;
    logic                w_last_bin;

    assign w_last_bin = (r_bin == BIN_BIT'(LEVELS - 1));

`ifdef CDF_MIN_EN
    logic [CW-1:0] r_cdf_min;
    logic          r_found;
    logic [CW-1:0] w_span;

    // Bins before the first occupied one, and single-bin images, map to 0.
    assign w_span     = CW'(TOTAL_PIXEL) - r_cdf_min;
    assign w_bypass   = !r_found || (w_span == '0);
    assign w_dividend = 32'(r_cdf - r_cdf_min) * 32'(LEVELS - 1);
    assign w_divisor  = w_span;
`else
    assign w_bypass   = (r_cdf == '0);
    assign w_dividend = 32'(r_cdf) * 32'(LEVELS - 1);
    assign w_divisor  = CW'(TOTAL_PIXEL);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        hist_rd_en   = 1'b0;
        hist_addr    = '0;
        div_start    = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        lut_we       = 1'b0;
        lut_addr     = '0;
        lut_data     = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RD;
                end
            end
            S_RD: begin
                busy         = 1'b1;
                hist_rd_en   = 1'b1;
                hist_addr    = r_bin;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                busy         = 1'b1;
                w_state_next = S_ACC;
            end
            S_ACC: begin
                busy         = 1'b1;
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                busy         = 1'b1;
                div_dividend = w_dividend;
                div_divisor  = w_divisor;
                if (w_bypass) begin
                    w_state_next = S_WR;
                end else begin
                    div_start    = 1'b1;
                    w_state_next = S_DIVW;
                end
            end
            S_DIVW: begin
                busy         = 1'b1;
                div_dividend = w_dividend;
                div_divisor  = w_divisor;
                if (div_done) begin
                    w_state_next = S_WR;
                end
            end
            S_WR: begin
                busy         = 1'b1;
                lut_we       = 1'b1;
                lut_addr     = r_bin;
                lut_data     = (|r_q[31:8]) ? 8'hFF : r_q[7:0];
                w_state_next = w_last_bin ? S_FIN : S_RD;
            end
            S_FIN: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin     <= '0;
            r_cdf     <= '0;
            r_q       <= '0;
`ifdef CDF_MIN_EN
            r_cdf_min <= '0;
            r_found   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin     <= '0;
                        r_cdf     <= '0;
`ifdef CDF_MIN_EN
                        r_cdf_min <= '0;
                        r_found   <= 1'b0;
`endif
                    end
                end
                S_ACC: begin
                    r_cdf <= r_cdf + hist_data;
`ifdef CDF_MIN_EN
                    if (!r_found && (hist_data != '0)) begin
                        r_cdf_min <= r_cdf + hist_data;
                        r_found   <= 1'b1;
                    end
`endif
                end
                S_LOAD: begin
                    if (w_bypass) begin
                        r_q <= '0;
                    end
                end
                S_DIVW: begin
                    if (div_done) begin
                        r_q <= div_quotient;
                    end
                end
                S_WR: begin
                    if (!w_last_bin) begin
                        r_bin <= r_bin + BIN_BIT'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
